// File: rtl/nvm_pkg.sv
// Shared types for the NVM pulse controller: phase encoding and default counter width.
package nvm_pkg;

  localparam int CNT_W_DEF = 8;

  // Encoding is visible on the phase output, so it must stay 0..3 in this order.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PULSE   = 2'd2,
    RECOVER = 2'd3
  } pulse_state_t;

endpackage

// File: rtl/nvm_pulse_ctrl_phase_timer.sv
// Up-counting phase timer: flags the final cycle of a phase of length max(len,1).
module phase_timer
  import nvm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             last,
  output logic             last_soon
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] lim;

  assign lim = (len == '0) ? '0 : (len - CNT_W'(1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign last      = (count_reg == lim);
  // True when the following cycle will be the final one if the phase keeps running.
  assign last_soon = ((count_reg + CNT_W'(1)) == lim);

endmodule

// File: rtl/nvm_pulse_ctrl.sv
// NVM cell access sequencer: SETUP -> PULSE -> RECOVER with per-access phase lengths and abort.
module nvm_pulse_ctrl
  import nvm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             op_write,
  input  logic [CNT_W-1:0] setup_len,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] recover_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       phase,
  output logic             wr_pulse,
  output logic             rd_en,
  output logic             sense_strobe
);

  pulse_state_t     state_reg, state_next;
  logic             op_reg, op_next;
  logic [CNT_W-1:0] setup_len_reg, pulse_len_reg, recover_len_reg;
  logic [CNT_W-1:0] pulse_len_eff, timer_len;
  logic             abort_pend_reg, abort_pend_next;
  logic             accept, abort_hit;
  logic             timer_clear, timer_en, timer_last, timer_last_soon;
  logic             final_pulse_next, done_next;
  logic             busy_reg, done_reg, aborted_reg, wr_pulse_reg, rd_en_reg, sense_strobe_reg;
  logic [1:0]       phase_reg;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (timer_clear),
    .en        (timer_en),
    .len       (timer_len),
    .last      (timer_last),
    .last_soon (timer_last_soon)
  );

  always_comb begin
    timer_len = '0;
    case (state_reg)
      SETUP:   timer_len = setup_len_reg;
      PULSE:   timer_len = pulse_len_reg;
      RECOVER: timer_len = recover_len_reg;
      default: timer_len = '0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    abort_hit     = 1'b0;
    accept        = (state_reg == IDLE) && start;
    op_next       = accept ? op_write : op_reg;
    pulse_len_eff = accept ? pulse_len : pulse_len_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (setup_len == '0) ? PULSE : SETUP;
      end
      SETUP: begin
        if (abort) begin
          abort_hit  = 1'b1;
          state_next = IDLE;
        end else if (timer_last) begin
          state_next = PULSE;
        end
      end
      PULSE: begin
        // Abort and normal end share a destination; abort only adds the aborted flag.
        if (abort || timer_last) begin
          abort_hit  = abort;
          state_next = (recover_len_reg == '0) ? IDLE : RECOVER;
        end
      end
      RECOVER: begin
        if (timer_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign timer_clear     = (state_next != state_reg);
  assign timer_en        = (state_reg != IDLE);
  assign abort_pend_next = accept ? 1'b0 : (abort_pend_reg | abort_hit);
  assign done_next       = (state_next == IDLE) && (state_reg != IDLE);
  // The strobe is registered, so it is decided on the edge that enters the final PULSE cycle.
  assign final_pulse_next = (state_reg == PULSE) ? timer_last_soon
                                                 : (pulse_len_eff <= CNT_W'(1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      op_reg          <= 1'b0;
      setup_len_reg   <= '0;
      pulse_len_reg   <= '0;
      recover_len_reg <= '0;
      abort_pend_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      abort_pend_reg <= abort_pend_next;
      if (accept) begin
        setup_len_reg   <= setup_len;
        pulse_len_reg   <= pulse_len;
        recover_len_reg <= recover_len;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      aborted_reg      <= 1'b0;
      phase_reg        <= 2'd0;
      wr_pulse_reg     <= 1'b0;
      rd_en_reg        <= 1'b0;
      sense_strobe_reg <= 1'b0;
    end else begin
      busy_reg         <= (state_next != IDLE);
      done_reg         <= done_next;
      aborted_reg      <= done_next && abort_pend_next;
      phase_reg        <= state_next;
      wr_pulse_reg     <= (state_next == PULSE) && op_next;
      rd_en_reg        <= (state_next == PULSE) && !op_next;
      sense_strobe_reg <= (state_next == PULSE) && !op_next && final_pulse_next;
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign aborted      = aborted_reg;
  assign phase        = phase_reg;
  assign wr_pulse     = wr_pulse_reg;
  assign rd_en        = rd_en_reg;
  assign sense_strobe = sense_strobe_reg;

endmodule

// File: tb/tb_nvm_pulse_ctrl.sv
// Bench for nvm_pulse_ctrl: directed timing cases plus random traffic against a schedule-queue model.
module tb_nvm_pulse_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       start = 1'b0;
  logic       op_write = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] setup_len = '0;
  logic [7:0] pulse_len = '0;
  logic [7:0] recover_len = '0;
  logic       busy, done, aborted, wr_pulse, rd_en, sense_strobe;
  logic [1:0] phase;
  logic [7:0] dut_vec;

  int checks = 0;
  int failures = 0;

  // Expected per-cycle output word: {phase, busy, done, aborted, wr, rd, strobe}
  typedef struct packed {
    logic [1:0] ph;
    logic busy, dn, ab, wr, rd, ss;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  logic [1:0] t1_ph [7];
  logic       t1_wr [7];
  logic [1:0] t5_ph [12];

  nvm_pulse_ctrl #(.CNT_W(8)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .start        (start),
    .op_write     (op_write),
    .setup_len    (setup_len),
    .pulse_len    (pulse_len),
    .recover_len  (recover_len),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .phase        (phase),
    .wr_pulse     (wr_pulse),
    .rd_en        (rd_en),
    .sense_strobe (sense_strobe)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {phase, busy, done, aborted, wr_pulse, rd_en, sense_strobe};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ph, input logic wr, input logic rd,
                              input logic ss, input logic dn);
    exp_t e;
    e.ph = ph; e.busy = (ph != 2'd0); e.dn = dn; e.ab = 1'b0;
    e.wr = wr; e.rd = rd; e.ss = ss;
    return e;
  endfunction

  // Whole access laid out as a list of cycles, ending in the done cycle.
  task automatic build_schedule();
    int p;
    p = (pulse_len == 0) ? 1 : int'(pulse_len);
    for (int i = 0; i < int'(setup_len); i++) q.push_back(mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < p; i++)
      q.push_back(mk(2'd2, op_write, !op_write, !op_write && (i == p - 1), 1'b0));
    for (int i = 0; i < int'(recover_len); i++) q.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      if (!nRST) begin
        q.delete();
        cur = '0;
      end else begin
        if (cur.ph == 2'd0) begin
          if (start) build_schedule();
        end else if (abort && cur.ph == 2'd1) begin
          q.delete();
          q.push_back(mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
          q[0].ab = 1'b1;
        end else if (abort && cur.ph == 2'd2) begin
          while (q.size() > 0 && q[0].ph == 2'd2) void'(q.pop_front());
          q[q.size()-1].ab = 1'b1;
        end
        cur = (q.size() > 0) ? q.pop_front() : '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (nRST) chk("cycle_outputs", {24'd0, dut_vec}, {24'd0, cur});
    end
  end

  // Presents an access at a negedge; returns at the negedge of its first busy cycle.
  task automatic launch(input logic op, input logic [7:0] s, input logic [7:0] p, input logic [7:0] r);
    @(negedge CLK);
    start = 1'b1; op_write = op; setup_len = s; pulse_len = p; recover_len = r;
    @(negedge CLK);
    start = 1'b0;
  endtask

  initial begin
    t1_ph = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    t1_wr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t5_ph = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    #12;
    chk("reset_outputs", {24'd0, dut_vec}, 32'd0);
    @(posedge CLK); #2 nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: write 2/3/1
    launch(1'b1, 8'd2, 8'd3, 8'd1);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge CLK);
      chk($sformatf("t1_phase_c%0d", k), {30'd0, phase}, {30'd0, t1_ph[k-1]});
      chk($sformatf("t1_wr_c%0d", k), {31'd0, wr_pulse}, {31'd0, t1_wr[k-1]});
    end
    chk("t1_done", {29'd0, busy, done, aborted}, 32'b010);
    repeat (2) @(negedge CLK);

    // 2: read 0/4/0
    launch(1'b0, 8'd0, 8'd4, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge CLK);
      chk($sformatf("t2_phase_c%0d", k), {30'd0, phase}, (k <= 4) ? 32'd2 : 32'd0);
      chk($sformatf("t2_rd_c%0d", k), {31'd0, rd_en}, (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("t2_ss_c%0d", k), {31'd0, sense_strobe}, (k == 4) ? 32'd1 : 32'd0);
    end
    chk("t2_done", {30'd0, done, aborted}, 32'b10);
    repeat (2) @(negedge CLK);

    // 3: write pulse 5 recover 2, abort in 2nd PULSE cycle
    launch(1'b1, 8'd0, 8'd5, 8'd2);
    chk("t3_wr_c1", {31'd0, wr_pulse}, 32'd1);
    @(negedge CLK);
    chk("t3_wr_c2", {31'd0, wr_pulse}, 32'd1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("t3_c3", {30'd0, phase, wr_pulse}, 32'b110);
    @(negedge CLK);
    chk("t3_c4", {30'd0, phase, done}, 32'b110);
    @(negedge CLK);
    chk("t3_c5", {29'd0, phase, done, aborted}, 32'b0011);
    repeat (2) @(negedge CLK);

    // 4: abort in SETUP
    launch(1'b1, 8'd4, 8'd3, 8'd1);
    chk("t4_c1", {29'd0, phase, wr_pulse}, 32'b010);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("t4_c2", {28'd0, phase, done, aborted, wr_pulse}, 32'b00110);
    repeat (2) @(negedge CLK);

    // 5: start held high, all lengths 1, then pulse_len 0
    @(negedge CLK);
    start = 1'b1; op_write = 1'b1; setup_len = 8'd1; pulse_len = 8'd1; recover_len = 8'd1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      chk($sformatf("t5_phase_c%0d", k), {30'd0, phase}, {30'd0, t5_ph[k-1]});
      chk($sformatf("t5_done_c%0d", k), {31'd0, done}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k == 5) pulse_len = 8'd0;
      if (k == 9) start = 1'b0;
    end
    repeat (2) @(negedge CLK);

    // 6: asynchronous reset during PULSE
    launch(1'b0, 8'd0, 8'd6, 8'd0);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1 chk("t6_async_reset", {24'd0, dut_vec}, 32'd0);
    @(posedge CLK); #2 nRST = 1'b1;
    @(negedge CLK);
    chk("t6_no_done", {29'd0, phase, done}, 32'd0);
    launch(1'b0, 8'd0, 8'd1, 8'd0);
    chk("t6_restart", {29'd0, phase, rd_en, sense_strobe}, 32'b1011);
    @(negedge CLK);
    chk("t6_restart_done", {31'd0, done}, 32'd1);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      @(negedge CLK);
      start       = ($urandom_range(0, 2) == 0);
      op_write    = $urandom_range(0, 1) == 1;
      setup_len   = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      pulse_len   = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      recover_len = ($urandom_range(0, 24) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      abort       = ($urandom_range(0, 9) == 0);
      if (n == 1200) begin
        #2 nRST = 1'b0;
        @(posedge CLK); #2 nRST = 1'b1;
      end
    end
    @(negedge CLK);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
